avalon_master_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares a single memory-facing master port, the SDRAM path, between two accelerator masters. Typical pairing: a dot-product engine and a second accelerator or DMA. It grants one requester at a time with round-robin fairness. It tracks outstanding reads in an owner FIFO so that each `readdatavalid` returns only to the requester that issued the read. Writes pass through on grant.

---
 rtl/avalon_master_arbiter.sv | 164 ++++++++++++++++
 tb/tb_avalon_master_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between two requesters.
// An owner FIFO routes each readdatavalid back to the requester that issued the read.
module avalon_master_arbiter #(
    parameter int MAX_PENDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        r0_waitrequest,
    input  logic [31:0] r0_address,
    input  logic        r0_read,
    input  logic        r0_write,
    input  logic [31:0] r0_writedata,
    output logic [31:0] r0_readdata,
    output logic        r0_readdatavalid,
    output logic        r1_waitrequest,
    input  logic [31:0] r1_address,
    input  logic        r1_read,
    input  logic        r1_write,
    input  logic [31:0] r1_writedata,
    output logic [31:0] r1_readdata,
    output logic        r1_readdatavalid,
    input  logic        mem_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic        spurious_rdv
);

    localparam int PW = $clog2(MAX_PENDING);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_MAX = MAX_PENDING[PW:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_q, last_d;
    logic [MAX_PENDING-1:0] owner_q;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PW:0]            count_q;
    logic                   spurious_q;

    logic        req0_s, req1_s, gid_s;
    logic        sel_read_s, sel_write_s, accept_s, push_s, pop_s;
    logic        fifo_full_s, fifo_empty_s, head_s;
    logic [31:0] sel_addr_s, sel_wdata_s;

    assign req0_s       = r0_read | r0_write;
    assign req1_s       = r1_read | r1_write;
    assign gid_s        = (state_q == ST_GNT1);
    assign sel_read_s   = gid_s ? r1_read      : r0_read;
    assign sel_write_s  = gid_s ? r1_write     : r0_write;
    assign sel_addr_s   = gid_s ? r1_address   : r0_address;
    assign sel_wdata_s  = gid_s ? r1_writedata : r0_writedata;
    // Full is judged on the registered count so a same-cycle pop cannot unblock a read.
    assign fifo_full_s  = (count_q == CNT_MAX);
    assign fifo_empty_s = (count_q == {(PW+1){1'b0}});
    assign head_s       = owner_q[rd_ptr_q];
    assign pop_s        = mem_readdatavalid & ~fifo_empty_s;

    assign r0_readdata      = mem_readdata;
    assign r1_readdata      = mem_readdata;
    assign r0_readdatavalid = pop_s & ~head_s;
    assign r1_readdatavalid = pop_s & head_s;
    assign spurious_rdv     = spurious_q;

    // Grant FSM next state and the muxed master-port drive.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        mem_address    = 32'h0000_0000;
        mem_writedata  = 32'h0000_0000;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        r0_waitrequest = 1'b1;
        r1_waitrequest = 1'b1;
        accept_s       = 1'b0;
        push_s         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_s && !req1_s) begin
                    state_d = ST_GNT0;
                end else if (req1_s && !req0_s) begin
                    state_d = ST_GNT1;
                end else if (req0_s && req1_s) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT0, ST_GNT1: begin
                mem_address   = sel_addr_s;
                mem_writedata = sel_wdata_s;
                mem_read      = sel_read_s & ~fifo_full_s;
                // A simultaneous read wins; the write is suppressed.
                mem_write     = sel_write_s & ~sel_read_s;
                if (gid_s) begin
                    r1_waitrequest = mem_waitrequest | (r1_read & fifo_full_s);
                end else begin
                    r0_waitrequest = mem_waitrequest | (r0_read & fifo_full_s);
                end
                accept_s = (mem_read | mem_write) & ~mem_waitrequest;
                if (accept_s) begin
                    last_d  = gid_s;
                    state_d = ST_IDLE;
                    push_s  = mem_read;
                end else if (!sel_read_s && !sel_write_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Owner FIFO of outstanding reads plus the sticky spurious-return flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= {MAX_PENDING{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {(PW+1){1'b0}};
            spurious_q <= 1'b0;
        end else begin
            if (push_s) begin
                owner_q[wr_ptr_q] <= gid_s;
                wr_ptr_q          <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (mem_readdatavalid && fifo_empty_s) begin
                spurious_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Directed bench for avalon_master_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later, well clear of the rising edge.
module tb_avalon_master_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_waitrequest, r1_waitrequest;
    logic [31:0] r0_address, r1_address, r0_writedata, r1_writedata;
    logic        r0_read, r1_read, r0_write, r1_write;
    logic [31:0] r0_readdata, r1_readdata;
    logic        r0_readdatavalid, r1_readdatavalid;
    logic        mem_waitrequest;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_readdatavalid;
    logic        spurious_rdv;

    int n_tests = 0;
    int n_fail  = 0;
    int accepts;

    always #5 clk = ~clk;

    avalon_master_arbiter #(.MAX_PENDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_waitrequest(r0_waitrequest), .r0_address(r0_address), .r0_read(r0_read),
        .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_readdata(r0_readdata),
        .r0_readdatavalid(r0_readdatavalid),
        .r1_waitrequest(r1_waitrequest), .r1_address(r1_address), .r1_read(r1_read),
        .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_readdata(r1_readdata),
        .r1_readdatavalid(r1_readdatavalid),
        .mem_waitrequest(mem_waitrequest), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .spurious_rdv(spurious_rdv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        r0_address = 32'h0; r1_address = 32'h0; r0_writedata = 32'h0; r1_writedata = 32'h0;
        r0_read = 1'b0; r1_read = 1'b0; r0_write = 1'b0; r1_write = 1'b0;
        mem_waitrequest = 1'b0; mem_readdata = 32'h0; mem_readdatavalid = 1'b0;

        // Reset values
        #2;
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_writedata", mem_writedata, 32'd0);
        chk("rst_r0_wait", {31'd0, r0_waitrequest}, 32'd1);
        chk("rst_r1_wait", {31'd0, r1_waitrequest}, 32'd1);
        chk("rst_r0_rdv", {31'd0, r0_readdatavalid}, 32'd0);
        chk("rst_spurious", {31'd0, spurious_rdv}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Single read from r0
        @(negedge clk); r0_read = 1'b1; r0_address = 32'h0000_0100;
        #1 chk("rd_idle_mem_read", {31'd0, mem_read}, 32'd0);
        @(negedge clk);
        #1 chk("rd_gnt_mem_read", {31'd0, mem_read}, 32'd1);
        chk("rd_gnt_addr", mem_address, 32'h0000_0100);
        chk("rd_gnt_r0_wait", {31'd0, r0_waitrequest}, 32'd0);
        chk("rd_gnt_r1_wait", {31'd0, r1_waitrequest}, 32'd1);
        @(negedge clk); r0_read = 1'b0;
        #1 chk("rd_after_mem_read", {31'd0, mem_read}, 32'd0);
        @(negedge clk);
        @(negedge clk); mem_readdatavalid = 1'b1; mem_readdata = 32'hDEAD_BEEF;
        #1 chk("rd_r0_rdv", {31'd0, r0_readdatavalid}, 32'd1);
        chk("rd_r0_data", r0_readdata, 32'hDEAD_BEEF);
        chk("rd_r1_rdv", {31'd0, r1_readdatavalid}, 32'd0);
        @(negedge clk); mem_readdatavalid = 1'b0;
        #1 chk("rd_no_spurious", {31'd0, spurious_rdv}, 32'd0);

        // Contention after reset: r0 wins first tie, then strict alternation
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        r0_read = 1'b1; r0_address = 32'h0000_0010;
        r1_read = 1'b1; r1_address = 32'h0000_0020;
        for (int k = 0; k < 4; k++) begin
            #1 chk("ct_idle_mem_read", {31'd0, mem_read}, 32'd0);
            @(negedge clk);
            #1 chk("ct_gnt_addr", mem_address, (k % 2 == 0) ? 32'h0000_0010 : 32'h0000_0020);
            chk("ct_gnt_r0_wait", {31'd0, r0_waitrequest}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("ct_gnt_r1_wait", {31'd0, r1_waitrequest}, (k % 2 == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        r0_read = 1'b0; r1_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); mem_readdatavalid = 1'b1; mem_readdata = k + 1;
            #1 chk("ct_r0_rdv", {31'd0, r0_readdatavalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("ct_r1_rdv", {31'd0, r1_readdatavalid}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("ct_data", (k % 2 == 0) ? r0_readdata : r1_readdata, k + 1);
        end
        @(negedge clk); mem_readdatavalid = 1'b0;
        #1 chk("ct_no_spurious", {31'd0, spurious_rdv}, 32'd0);

        // FIFO full: four reads outstanding block the fifth until a return
        @(negedge clk); r0_read = 1'b1; r0_address = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            #1 chk("ff_idle_mem_read", {31'd0, mem_read}, 32'd0);
            @(negedge clk);
            #1 chk("ff_gnt_mem_read", {31'd0, mem_read}, 32'd1);
            @(negedge clk);
        end
        @(negedge clk);
        #1 chk("ff_full_mem_read", {31'd0, mem_read}, 32'd0);
        chk("ff_full_r0_wait", {31'd0, r0_waitrequest}, 32'd1);
        @(negedge clk); mem_readdatavalid = 1'b1; mem_readdata = 32'h0000_000A;
        #1 chk("ff_pop_r0_rdv", {31'd0, r0_readdatavalid}, 32'd1);
        chk("ff_pop_mem_read", {31'd0, mem_read}, 32'd0);
        chk("ff_pop_r0_wait", {31'd0, r0_waitrequest}, 32'd1);
        @(negedge clk); mem_readdatavalid = 1'b0;
        #1 chk("ff_next_mem_read", {31'd0, mem_read}, 32'd1);
        chk("ff_next_r0_wait", {31'd0, r0_waitrequest}, 32'd0);
        @(negedge clk); r0_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); mem_readdatavalid = 1'b1;
            #1 chk("ff_drain_r0_rdv", {31'd0, r0_readdatavalid}, 32'd1);
        end
        @(negedge clk); mem_readdatavalid = 1'b0;
        #1 chk("ff_no_spurious", {31'd0, spurious_rdv}, 32'd0);

        // Stalled r1 write
        accepts = 0;
        @(negedge clk);
        r1_write = 1'b1; r1_address = 32'h0000_0200; r1_writedata = 32'h0000_0055;
        mem_waitrequest = 1'b1;
        #1 chk("st_idle_mem_write", {31'd0, mem_write}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 chk("st_addr", mem_address, 32'h0000_0200);
            chk("st_data", mem_writedata, 32'h0000_0055);
            chk("st_mem_write", {31'd0, mem_write}, 32'd1);
            chk("st_r1_wait", {31'd0, r1_waitrequest}, 32'd1);
            chk("st_r0_wait", {31'd0, r0_waitrequest}, 32'd1);
            if (mem_write && !mem_waitrequest) accepts++;
        end
        @(negedge clk); mem_waitrequest = 1'b0;
        #1 chk("st_acc_addr", mem_address, 32'h0000_0200);
        chk("st_acc_r1_wait", {31'd0, r1_waitrequest}, 32'd0);
        if (mem_write && !mem_waitrequest) accepts++;
        @(negedge clk); r1_write = 1'b0;
        #1 chk("st_after_mem_write", {31'd0, mem_write}, 32'd0);
        chk("st_accepts", accepts, 32'd1);

        // Spurious return with empty FIFO
        @(negedge clk); mem_readdatavalid = 1'b1; mem_readdata = 32'h1234_5678;
        #1 chk("sp_r0_rdv", {31'd0, r0_readdatavalid}, 32'd0);
        chk("sp_r1_rdv", {31'd0, r1_readdatavalid}, 32'd0);
        chk("sp_before", {31'd0, spurious_rdv}, 32'd0);
        @(negedge clk); mem_readdatavalid = 1'b0;
        #1 chk("sp_set", {31'd0, spurious_rdv}, 32'd1);
        repeat (3) @(negedge clk);
        #1 chk("sp_sticky", {31'd0, spurious_rdv}, 32'd1);
        rst_n = 1'b0;
        #1 chk("sp_cleared", {31'd0, spurious_rdv}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Reset with two reads outstanding and a third granted
        @(negedge clk); r0_read = 1'b1; r0_address = 32'h0000_0400;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk("rm_gnt_mem_read", {31'd0, mem_read}, 32'd1);
            if (k < 2) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1 chk("rm_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rm_mem_address", mem_address, 32'd0);
        chk("rm_r0_wait", {31'd0, r0_waitrequest}, 32'd1);
        r0_read = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); mem_readdatavalid = 1'b1;
        #1 chk("rm_late1_r0_rdv", {31'd0, r0_readdatavalid}, 32'd0);
        chk("rm_late1_r1_rdv", {31'd0, r1_readdatavalid}, 32'd0);
        @(negedge clk);
        #1 chk("rm_late2_r0_rdv", {31'd0, r0_readdatavalid}, 32'd0);
        chk("rm_spurious_set", {31'd0, spurious_rdv}, 32'd1);
        @(negedge clk); mem_readdatavalid = 1'b0;
        #1 chk("rm_spurious_hold", {31'd0, spurious_rdv}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
